// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the
// bit-period helper also used by uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per bit, truncated toward zero.
    function automatic int uart_cycles(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input, with a previous-value
// register for falling-edge detection. Everything resets to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit majority voting, a single-entry valid/ready
// holding register and one-cycle framing/overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CYCLE = uart_cycles(CLK_FRE, BAUD_RATE);
    localparam int HALF  = CYCLE / 2;

    // Start bit is voted half a bit in; later bits one full bit after each re-arm.
    localparam logic [15:0] START_MID = 16'(HALF);
    localparam logic [15:0] DATA_MID  = 16'(CYCLE - 1);
    localparam logic [15:0] BREAK_END = 16'(CYCLE - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t   state;
    rx_state_t   state_next;
    logic        rx_s;
    logic        fall;
    logic [15:0] cnt;
    logic [15:0] mid;
    logic [2:0]  bit_idx;
    logic        s1;
    logic        s2;
    logic        vote;
    logic        vote_now;
    logic        break_done;
    logic [7:0]  shreg;
    logic        frame_ok;
    logic        frame_bad;
    logic        load;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (rx_pin),
        .level (rx_s),
        .fall  (fall)
    );

    assign mid        = (state == START) ? START_MID : DATA_MID;
    assign vote_now   = (state inside {START, DATA, STOP}) && (cnt == mid + 16'd1);
    assign vote       = (s1 & s2) | (s1 & rx_s) | (s2 & rx_s);
    assign break_done = (state == BREAK) && rx_s && (cnt == BREAK_END);
    assign frame_ok   = (state == STOP) && vote_now && vote;
    assign frame_bad  = (state == STOP) && vote_now && !vote;
    assign load       = frame_ok && (!rx_data_valid || rx_data_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall) state_next = START;
            START:   if (vote_now) state_next = vote ? IDLE : DATA;
            DATA:    if (vote_now && bit_idx == LAST_BIT) state_next = STOP;
            STOP:    if (vote_now) state_next = vote ? IDLE : BREAK;
            BREAK:   if (break_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // In BREAK the counter measures how long the line has been continuously high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            s1      <= 1'b1;
            s2      <= 1'b1;
            shreg   <= 8'd0;
        end else begin
            case (state)
                IDLE:    cnt <= 16'd0;
                BREAK:   cnt <= rx_s ? cnt + 16'd1 : 16'd0;
                default: cnt <= vote_now ? 16'd0 : cnt + 16'd1;
            endcase
            if (cnt == mid - 16'd1) s1 <= rx_s;
            if (cnt == mid) s2 <= rx_s;
            if (state == START && vote_now) bit_idx <= 3'd0;
            if (state == DATA && vote_now) begin
                bit_idx <= bit_idx + 3'd1;
                shreg   <= {vote, shreg[7:1]};
            end
        end
    end

    // A byte arriving while the previous one is still held is dropped, unless
    // the consumer takes the old byte in that very cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= 8'd0;
            rx_data_valid <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (load) begin
                rx_data       <= shreg;
                rx_data_valid <= 1'b1;
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
            frame_err <= frame_bad;
            overrun   <= frame_ok && rx_data_valid && !rx_data_ready;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed-plus-random bench for uart_rx: drives 8N1 frames on rx_pin and
// compares delivered bytes and error pulses against an expected-byte model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CYCLE = uart_cycles(27, 115200);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_pin = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int ready_mode = 2;
    int vcyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int v0, f0, o0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];

    uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Ready modes: 0 random backpressure, 1 held low, 2 held high, 3 driven by the main sequence.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: rx_data_ready = ($urandom_range(0, 3) == 0);
                1: rx_data_ready = 1'b0;
                2: rx_data_ready = 1'b1;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
            if (rx_data_valid) vcyc++;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx_pin = 1'b0;
        repeat (CYCLE) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = data[i];
            repeat (CYCLE) @(negedge clk);
        end
        rx_pin = stop_bit;
        repeat (CYCLE) @(negedge clk);
    endtask

    task snap();
        v0 = vcyc;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
    endtask

    task checkQueue(input string tag);
        checkOutput({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                checkOutput($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        string msg;
        byte unsigned b;

        repeat (5) @(negedge clk);
        checkOutput("reset outputs", {21'd0, rx_data, rx_data_valid, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] nominal byte 0x55");
        ready_mode = 2;
        snap();
        exp_q.push_back(8'h55);
        applyStimulus(8'h55, 1'b1);
        repeat (40) @(negedge clk);
        checkQueue("nominal");
        checkOutput("nominal valid cycles", 32'(vcyc - v0), 32'd1);
        checkOutput("nominal frame_err", 32'(ferr_cnt - f0), 32'd0);
        checkOutput("nominal overrun", 32'(ovr_cnt - o0), 32'd0);
        checkOutput("nominal rx_data held", 32'(rx_data), 32'h55);

        $display("[TB] back-to-back string with backpressure");
        ready_mode = 0;
        snap();
        msg = "Hello World A";
        for (int i = 0; i < msg.len(); i++) begin
            b = msg[i];
            exp_q.push_back(b);
            applyStimulus(b, 1'b1);
        end
        exp_q.push_back(8'h0D);
        applyStimulus(8'h0D, 1'b1);
        exp_q.push_back(8'h0A);
        applyStimulus(8'h0A, 1'b1);
        repeat (40) @(negedge clk);
        checkQueue("string");
        checkOutput("string overrun", 32'(ovr_cnt - o0), 32'd0);
        checkOutput("string frame_err", 32'(ferr_cnt - f0), 32'd0);

        $display("[TB] random bytes");
        snap();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            applyStimulus(b, 1'b1);
        end
        repeat (40) @(negedge clk);
        checkQueue("random");
        checkOutput("random overrun", 32'(ovr_cnt - o0), 32'd0);

        $display("[TB] glitch rejection");
        ready_mode = 2;
        snap();
        rx_pin = 1'b0;
        repeat (50) @(negedge clk);
        rx_pin = 1'b1;
        repeat (80) @(negedge clk);
        checkOutput("glitch idle by 130", 32'(dut.state), 32'(IDLE));
        repeat (200) @(negedge clk);
        checkOutput("glitch valid cycles", 32'(vcyc - v0), 32'd0);
        checkOutput("glitch frame_err", 32'(ferr_cnt - f0), 32'd0);
        checkOutput("glitch bytes", 32'(got_q.size()), 32'd0);

        $display("[TB] framing error and break");
        snap();
        applyStimulus(8'h41, 1'b0);
        repeat (5 * CYCLE) @(negedge clk);
        rx_pin = 1'b1;
        repeat (2 * CYCLE) @(negedge clk);
        checkOutput("break frame_err", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("break valid cycles", 32'(vcyc - v0), 32'd0);
        exp_q.push_back(8'h42);
        applyStimulus(8'h42, 1'b1);
        repeat (40) @(negedge clk);
        checkQueue("after break");
        checkOutput("after break frame_err", 32'(ferr_cnt - f0), 32'd1);

        $display("[TB] overrun");
        ready_mode = 1;
        repeat (5) @(negedge clk);
        snap();
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h32, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("overrun rx_data", 32'(rx_data), 32'h31);
        checkOutput("overrun valid", 32'(rx_data_valid), 32'd1);
        checkOutput("overrun pulses", 32'(ovr_cnt - o0), 32'd1);
        ready_mode = 3;
        @(posedge clk);
        #1 rx_data_ready = 1'b1;
        @(posedge clk);
        #1 rx_data_ready = 1'b0;
        @(negedge clk);
        checkOutput("overrun valid after accept", 32'(rx_data_valid), 32'd0);
        exp_q.push_back(8'h31);
        checkQueue("overrun");

        $display("[TB] reset mid-frame");
        ready_mode = 2;
        snap();
        rx_pin = 1'b0;
        repeat (CYCLE) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_pin = 1'b0;
            repeat (CYCLE) @(negedge clk);
        end
        rx_pin = 1'b1;
        repeat (CYCLE / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("mid-frame reset outputs", {21'd0, rx_data, rx_data_valid, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (CYCLE / 2 + 4 * CYCLE) @(negedge clk);
        checkOutput("post reset bytes", 32'(got_q.size()), 32'd0);
        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        repeat (40) @(negedge clk);
        checkQueue("after reset");
        checkOutput("after reset frame_err", 32'(ferr_cnt - f0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
